// File: rtl/pixie_dp_back_end_if.sv
// rtl/pixie_dp_back_end_if.sv - frame-buffer read port and video timing bundle
// Purpose: groups the Pixie back end's RAM read port and its video output signals.
// Signals:
//   mem_rd_addr  [9:0]  frame-buffer read address {row[6:0], byte[2:0]}
//   mem_rd_data  [7:0]  RAM read data, valid 1 clk after mem_rd_addr changes
//   video, hsync, vsync, hblank, vblank, de, frame_start  video stage outputs
// Modports: master = back end (drives address and video), slave = RAM / mixer side.
interface pixie_dp_back_end_if;
  logic [9:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       video;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic       de;
  logic       frame_start;

  modport master (
    output mem_rd_addr,
    input  mem_rd_data,
    output video, hsync, vsync, hblank, vblank, de, frame_start
  );

  modport slave (
    input  mem_rd_addr,
    output mem_rd_data,
    input  video, hsync, vsync, hblank, vblank, de, frame_start
  );
endinterface

// File: rtl/pixie_dp_back_end.sv
// rtl/pixie_dp_back_end.sv - Pixie scan-out: frame buffer to 1-bit video with timing
// Purpose: scans the 8x128-byte frame buffer and serialises it MSB first into a
//   64x128 mono pixel stream with hsync/vsync/blank/de and a frame_start pulse.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   clk_enable     pixel tick; all state advances only when high (spacing >= 2 clk)
//   disp_en        display enable; low forces video to 0, timing keeps running
//   border         border pixel value, used only when PIXIE_BE_BORDER_EN is defined
//   vid_if         master side of pixie_dp_back_end_if (RAM read port + video outputs)
// Option: PIXIE_BE_BORDER_EN - drive video = border & disp_en in the visible area
//   outside de; when undefined video is 0 outside de and border is ignored.
module pixie_dp_back_end (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic                       disp_en,
  input  logic                       border,
  pixie_dp_back_end_if.master        vid_if
);

  localparam logic [6:0] H_LAST       = 7'd111;
  localparam logic [6:0] H_ACT_START  = 7'd8;
  localparam logic [6:0] H_ACT_END    = 7'd72;
  localparam logic [6:0] H_VIS_END    = 7'd80;
  localparam logic [6:0] HSYNC_START  = 7'd88;
  localparam logic [6:0] HSYNC_END    = 7'd96;
  localparam logic [8:0] V_LAST       = 9'd261;
  localparam logic [8:0] V_ACT_START  = 9'd80;
  localparam logic [8:0] V_ACT_END    = 9'd208;
  localparam logic [8:0] V_VIS_START  = 9'd64;
  localparam logic [8:0] V_VIS_END    = 9'd224;
  localparam logic [8:0] VSYNC_START  = 9'd240;
  localparam logic [8:0] VSYNC_END    = 9'd244;

  logic [6:0] hc_q, hc_d;
  logic [8:0] vc_q, vc_d;
  logic [7:0] shift_q, shift_d;
  logic [9:0] addr_q, addr_d;
  logic       video_q, video_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;

  logic       h_act, v_act, h_vis, v_vis, pix, border_pix;

  always_comb begin
    hc_d = hc_q + 7'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 9'd1;
    end

    h_act = (hc_q >= H_ACT_START) && (hc_q < H_ACT_END);
    v_act = (vc_q >= V_ACT_START) && (vc_q < V_ACT_END);
    h_vis = (hc_q < H_VIS_END);
    v_vis = (vc_q >= V_VIS_START) && (vc_q < V_VIS_END);

    de_d     = h_act && v_act;
    hblank_d = !h_vis;
    vblank_d = !v_vis;
    hsync_d  = (hc_q >= HSYNC_START) && (hc_q < HSYNC_END);
    vsync_d  = (vc_q >= VSYNC_START) && (vc_q < VSYNC_END);
    fs_d     = (hc_q == '0) && (vc_q == '0);

    // Prefetch one tick ahead of each byte slot: hc = 7,15,..,63 selects byte hc[5:3].
    // Row is vc-80 mod 128, which only needs the low 7 bits of vc.
    addr_d = addr_q;
    if (v_act && !hc_q[6] && (hc_q[2:0] == 3'd7)) begin
      addr_d = {vc_q[6:0] - 7'd80, hc_q[5:3]};
    end

    // Byte slot boundaries inside de fall on hc multiples of 8 (8..64).
    shift_d = shift_q;
    pix     = 1'b0;
    if (de_d) begin
      if (hc_q[2:0] == 3'd0) begin
        shift_d = vid_if.mem_rd_data;
        pix     = vid_if.mem_rd_data[7];
      end else begin
        pix     = shift_q[6];
        shift_d = {shift_q[6:0], 1'b0};
      end
    end

`ifdef PIXIE_BE_BORDER_EN
    border_pix = h_vis && v_vis && border && disp_en;
`else
    border_pix = 1'b0 & border;
`endif

    video_d = de_d ? (pix && disp_en) : border_pix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q     <= '0;
      vc_q     <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      video_q  <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else if (clk_enable) begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      video_q  <= video_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
    end
  end

  assign vid_if.mem_rd_addr = addr_q;
  assign vid_if.video       = video_q;
  assign vid_if.hsync       = hsync_q;
  assign vid_if.vsync       = vsync_q;
  assign vid_if.hblank      = hblank_q;
  assign vid_if.vblank      = vblank_q;
  assign vid_if.de          = de_q;
  assign vid_if.frame_start = fs_q;

endmodule

// File: tb/tb_pixie_dp_back_end.sv
// tb/tb_pixie_dp_back_end.sv - scoreboard bench for pixie_dp_back_end
module tb_pixie_dp_back_end;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;
  logic disp_en;
  logic border;

  always #5 clk = ~clk;

  pixie_dp_back_end_if vif ();

  pixie_dp_back_end dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .disp_en    (disp_en),
    .border     (border),
    .vid_if     (vif.master)
  );

  logic [7:0] ram [1024];
  always @(posedge clk) vif.mem_rd_data <= ram[vif.mem_rd_addr];

  // {video, hsync, vsync, hblank, vblank, de, frame_start, mem_rd_addr[9:0]}
  logic [16:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  int         mh = 0;
  int         mv = 0;
  logic [9:0] maddr = '0;

  task automatic model_step(output logic [16:0] e);
    bit de, vis_h, vis_v, hs, vs, fs, pix, vid;
    logic [7:0] b;
    de    = (mh >= 8 && mh < 72 && mv >= 80 && mv < 208);
    vis_h = (mh < 80);
    vis_v = (mv >= 64 && mv < 224);
    hs    = (mh >= 88 && mh < 96);
    vs    = (mv >= 240 && mv < 244);
    fs    = (mh == 0 && mv == 0);
    pix   = 1'b0;
    if (de) begin
      b   = ram[(mv - 80) * 8 + (mh - 8) / 8];
      pix = b[7 - ((mh - 8) % 8)];
    end
`ifdef PIXIE_BE_BORDER_EN
    vid = de ? (pix & disp_en) : (vis_h & vis_v & border & disp_en);
`else
    vid = de ? (pix & disp_en) : 1'b0;
`endif
    if (mv >= 80 && mv < 208 && mh < 64 && (mh % 8) == 7)
      maddr = 10'((mv - 80) * 8 + mh / 8);
    e = {vid, hs, vs, !vis_h, !vis_v, de, fs, maddr};
    mh = mh + 1;
    if (mh == 112) begin
      mh = 0;
      mv = (mv == 261) ? 0 : mv + 1;
    end
  endtask

  task automatic tick(input bit rst);
    logic [16:0] e;
    @(negedge clk);
    reset      = rst;
    clk_enable = 1'b1;
    if (rst) begin
      mh = 0; mv = 0; maddr = '0;
      exp_q.push_back(17'd0);
    end else begin
      model_step(e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    clk_enable = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    reset      = 1'b1;
    clk_enable = 1'b0;
    mh = 0; mv = 0; maddr = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares every enabled tick, plus per-frame aggregate timing counts.
  initial begin
    logic [16:0] got, e;
    bit en, rs, fr_valid;
    int de_cnt, hs_cnt, vs_cnt;
    fr_valid = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    forever begin
      @(posedge clk);
      en = clk_enable;
      rs = reset;
      #1;
      if (rs) fr_valid = 0;
      if (en) begin
        got = {vif.video, vif.hsync, vif.vsync, vif.hblank, vif.vblank,
               vif.de, vif.frame_start, vif.mem_rd_addr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_underflow: got=%h required=<queued expectation>", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL tick_outputs at %0t: got=%h required=%h", $time, got, e);
          end
        end
        if (!rs) begin
          if (vif.frame_start) begin
            if (fr_valid) begin
              checks += 3;
              if (de_cnt != 8192) begin
                errors++;
                $display("FAIL de_per_frame: got=%0d required=8192", de_cnt);
              end
              if (hs_cnt != 2096) begin
                errors++;
                $display("FAIL hsync_per_frame: got=%0d required=2096", hs_cnt);
              end
              if (vs_cnt != 448) begin
                errors++;
                $display("FAIL vsync_width: got=%0d required=448", vs_cnt);
              end
            end
            fr_valid = 1;
            de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
          end
          de_cnt += int'(vif.de);
          hs_cnt += int'(vif.hsync);
          vs_cnt += int'(vif.vsync);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    ram[0]    = 8'h80;
    ram[8]    = 8'hFF;
    ram[1023] = 8'h01;
    reset      = 1'b1;
    clk_enable = 1'b0;
    disp_en    = 1'b1;
    border     = 1'b0;

    // Reset held across three edges, one of them enabled.
    tick(1'b1);

    // One full frame plus a few ticks so the second frame_start is seen.
    for (int i = 0; i < 29350; i++) begin
      if (i > 40000 - 1) disp_en = 1'b1;
      if ($urandom_range(0, 299) == 0) disp_en = ~disp_en;
      border = 1'($urandom);
      tick(1'b0);
    end

    for (int i = 0, n = $urandom_range(1, 150); i < n; i++) tick(1'b0);
    mid_reset();

    // Restart from h=0,v=0 and run into the active area with frequent disp_en toggles.
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 19) == 0) disp_en = ~disp_en;
      border = 1'($urandom);
      tick(1'b0);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
